md_sched: RTL



---
 rtl/md_sched.sv | 137 +++++++++++++
 1 files changed

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multiply/divide sequencer owning HI/LO, with pipeline stall request
// Fixed-length busy window per op class; the result is computed from latched operands and committed on the last busy edge.
module md_sched #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        E_mdStart,
   input  logic [2:0]  E_mdOp,
   input  logic [31:0] E_A,
   input  logic [31:0] E_B,
   input  logic        D_mdUse,
   output logic        md_busy,
   output logic        stall_req,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   typedef enum logic {IDLE, BUSY} state_e;

   localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
   localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [31:0] opa_q, opa_d;
   logic [31:0] opb_q, opb_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   logic [63:0] prod_s, prod_u;
   logic        div_signed, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
   logic        e_long;

   // Lower 64 bits of a product of sign-extended operands equal the signed product.
   always_comb begin
      prod_s = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
      prod_u = {32'b0, opa_q} * {32'b0, opb_q};
   end

   // Divide on magnitudes, then restore signs; 0x80000000 / -1 falls out as 0x80000000 rem 0.
   always_comb begin
      div_signed = (op_q == OP_DIV);
      a_neg      = div_signed & opa_q[31];
      b_neg      = div_signed & opb_q[31];
      a_mag      = a_neg ? (32'd0 - opa_q) : opa_q;
      b_mag      = b_neg ? (32'd0 - opb_q) : opb_q;
      q_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
      r_mag      = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
      quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
      rem        = a_neg ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      case (state_q)
         IDLE: begin
            if (E_mdStart) begin
               case (E_mdOp)
                  OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                     op_d    = E_mdOp;
                     opa_d   = E_A;
                     opb_d   = E_B;
                     cnt_d   = (E_mdOp == OP_MULT || E_mdOp == OP_MULTU) ? MULT_N : DIV_N;
                     state_d = BUSY;
                  end
                  OP_MTHI: hi_d = E_A;
                  OP_MTLO: lo_d = E_A;
                  default: ;
               endcase
            end
         end
         BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
               case (op_q)
                  OP_MULT:  {hi_d, lo_d} = prod_s;
                  OP_MULTU: {hi_d, lo_d} = prod_u;
                  OP_DIV, OP_DIVU: begin
                     if (opb_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                     end
                  end
                  default: ;
               endcase
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         op_q    <= 3'd0;
         opa_q   <= 32'd0;
         opb_q   <= 32'd0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign e_long    = E_mdStart && (E_mdOp >= OP_MULT) && (E_mdOp <= OP_DIVU);
   assign md_busy   = (state_q == BUSY);
   assign stall_req = D_mdUse & (md_busy | e_long);
   assign HI        = hi_q;
   assign LO        = lo_q;

endmodule
